// File: rtl/mem_arbiter.sv
// Byte-wide memory bus sequencer shared by the instruction fetcher and the load/store buffer.
// Optional build macro MEM_ARB_FAIR_EN: alternate the winner when both requesters collide.
module mem_arbiter #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              flush_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t              state_r;
    logic                owner_ls_r;
    logic [ADDR_W-1:0]   base_r;
    logic [2:0]          n_beats_r;
    logic [31:0]         wdata_r;
    logic [2:0]          issue_cnt_r;
    logic [2:0]          recv_cnt_r;
    logic                on_bus_r;    // a read address is on mem_a this cycle
    logic                data_due_r;  // mem_din carries the byte for lane recv_cnt_r
    logic [31:0]         rd_buf_r;
`ifdef MEM_ARB_FAIR_EN
    logic                last_ls_r;
`endif

    logic                want_if_s;
    logic                pick_ls_s;
    logic                grant_s;
    logic                io_stall_s;
    logic                last_capture_s;
    logic [31:0]         merged_s;
    logic [7:0]          wbyte_s;

    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Arbitration between the two requesters and grant qualification.
    always_comb begin
        want_if_s = if_req && !flush_in;
`ifdef MEM_ARB_FAIR_EN
        if (ls_req && want_if_s) begin
            pick_ls_s = !last_ls_r;
        end else begin
            pick_ls_s = ls_req;
        end
`else
        pick_ls_s = ls_req;
`endif
        grant_s = rdy_in && (ls_req || want_if_s);
    end

    // Beat datapath: read-lane merge, write byte select, IO stall and completion detect.
    always_comb begin
        merged_s = rd_buf_r;
        merged_s[{recv_cnt_r[1:0], 3'b000} +: 8] = mem_din;
        wbyte_s = wdata_r[{issue_cnt_r[1:0], 3'b000} +: 8];
        io_stall_s = (base_r[17:16] == IO_HI) && io_buffer_full;
        last_capture_s = data_due_r && ((recv_cnt_r + 3'd1) == n_beats_r);
    end

    // Sequencer FSM with registered bus and completion outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= IDLE;
            owner_ls_r  <= 1'b0;
            base_r      <= {ADDR_W{1'b0}};
            n_beats_r   <= 3'd0;
            wdata_r     <= 32'h0000_0000;
            issue_cnt_r <= 3'd0;
            recv_cnt_r  <= 3'd0;
            on_bus_r    <= 1'b0;
            data_due_r  <= 1'b0;
            rd_buf_r    <= 32'h0000_0000;
            mem_wr      <= 1'b0;
            mem_a       <= {ADDR_W{1'b0}};
            mem_dout    <= 8'h00;
            if_done     <= 1'b0;
            ls_done     <= 1'b0;
            if_data     <= 32'h0000_0000;
            ls_rdata    <= 32'h0000_0000;
`ifdef MEM_ARB_FAIR_EN
            last_ls_r   <= 1'b0;
`endif
        end else begin
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            mem_wr     <= 1'b0;
            on_bus_r   <= 1'b0;
            data_due_r <= on_bus_r;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_ls_r  <= pick_ls_s;
                        base_r      <= pick_ls_s ? ls_addr : if_addr;
                        n_beats_r   <= pick_ls_s ? beats_for_size(ls_size) : 3'd4;
                        wdata_r     <= ls_wdata;
                        issue_cnt_r <= 3'd0;
                        recv_cnt_r  <= 3'd0;
                        rd_buf_r    <= 32'h0000_0000;
                        state_r     <= (pick_ls_s && ls_we) ? WRITE : READ;
`ifdef MEM_ARB_FAIR_EN
                        last_ls_r   <= pick_ls_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (!owner_ls_r && flush_in) begin
                        // Fetch aborted: drop in-flight bytes and any pending completion.
                        state_r     <= IDLE;
                        data_due_r  <= 1'b0;
                        issue_cnt_r <= 3'd0;
                        recv_cnt_r  <= 3'd0;
                    end else begin
                        if (rdy_in && (issue_cnt_r < n_beats_r)) begin
                            mem_a       <= base_r + ADDR_W'(issue_cnt_r);
                            issue_cnt_r <= issue_cnt_r + 3'd1;
                            on_bus_r    <= 1'b1;
                        end
                        if (data_due_r) begin
                            rd_buf_r   <= merged_s;
                            recv_cnt_r <= recv_cnt_r + 3'd1;
                        end
                        if (last_capture_s) begin
                            if (owner_ls_r) begin
                                ls_done  <= 1'b1;
                                ls_rdata <= merged_s;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= merged_s;
                            end
                            state_r <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (issue_cnt_r == n_beats_r) begin
                        ls_done <= 1'b1;
                        state_r <= IDLE;
                    end else if (rdy_in && !io_stall_s) begin
                        mem_a       <= base_r + ADDR_W'(issue_cnt_r);
                        mem_dout    <= wbyte_s;
                        mem_wr      <= 1'b1;
                        issue_cnt_r <= issue_cnt_r + 3'd1;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a synchronous-read byte memory model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        flush_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int if_done_cnt = 0;
    int ls_done_cnt = 0;

    logic [31:0] log_a  [0:63];
    logic        log_wr [0:63];
    logic [7:0]  log_d  [0:63];
    int          done_who;
    logic [31:0] done_data;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .flush_in(flush_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        logic [7:0] b;
        case (a)
            32'h0000_0100: b = 8'h13;
            32'h0000_0101: b = 8'h05;
            32'h0000_0102: b = 8'h00;
            32'h0000_0103: b = 8'h00;
            32'h0000_0010: b = 8'h34;
            32'h0000_0011: b = 8'h92;
            32'h0000_0012: b = 8'hFF;
            32'h0000_0013: b = 8'hFF;
            default:       b = a[7:0] ^ 8'h5A;
        endcase
        return b;
    endfunction

    // Synchronous-read memory: data for the address on the bus appears the next cycle.
    always @(posedge clk_in) begin
        mem_din <= rom_byte(mem_a);
    end

    // Completion pulse counters, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (if_done) if_done_cnt <= if_done_cnt + 1;
        if (ls_done) ls_done_cnt <= ls_done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // k = 0 is the grant edge; lat is the tick index at which a done pulse is seen.
    task automatic run_txn(input int max_k, input int full_n, input int rlo_a, input int rlo_b,
                           output int lat);
        lat = -1;
        done_who = 0;
        done_data = 32'h0;
        for (int k = 0; k <= max_k; k++) begin
            io_buffer_full = (k >= 1) && (k <= full_n);
            rdy_in = !((k >= rlo_a) && (k <= rlo_b));
            tick();
            log_a[k]  = mem_a;
            log_wr[k] = mem_wr;
            log_d[k]  = mem_dout;
            if (if_done || ls_done) begin
                done_who  = if_done ? 1 : 2;
                done_data = if_done ? if_data : ls_rdata;
                if (if_done) if_req = 1'b0;
                if (ls_done) ls_req = 1'b0;
                lat = k;
                break;
            end
        end
        io_buffer_full = 1'b0;
        rdy_in = 1'b1;
    endtask

    initial begin
        int lat;
        int snap;
        int exp_first;
        logic [31:0] w;

        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_in = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
        tick(); tick(); tick();
        check_val("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check_val("rst_mem_a", mem_a, 32'h0);
        check_val("rst_if_done", {31'h0, if_done}, 32'h0);
        check_val("rst_ls_done", {31'h0, ls_done}, 32'h0);
        check_val("rst_if_data", if_data, 32'h0);
        check_val("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;
        tick();

        // Plain fetch
        if_addr = 32'h0000_0100; if_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("fetch_lat", lat, 32'd6);
        check_val("fetch_who", done_who, 32'd1);
        check_val("fetch_data", done_data, 32'h0000_0513);
        for (int k = 1; k <= 4; k++) check_val("fetch_addr", log_a[k], 32'h100 + k - 1);
        check_val("fetch_no_wr", {31'h0, log_wr[1]}, 32'h0);

        // Collision: LSB first in both builds (last grant was a fetch)
        ls_addr = 32'h0000_0010; ls_size = 2'b01; ls_we = 1'b0; ls_req = 1'b1;
        if_addr = 32'h0000_0100; if_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("coll1_who", done_who, 32'd2);
        check_val("coll1_lat", lat, 32'd4);
        check_val("coll1_half", done_data, 32'h0000_9234);
        run_txn(20, 0, 99, 99, lat);
        check_val("coll1_fetch_who", done_who, 32'd1);
        check_val("coll1_fetch_lat", lat, 32'd6);
        check_val("coll1_fetch_data", done_data, 32'h0000_0513);

        // Store word
        w = 32'hDEAD_BEEF;
        ls_addr = 32'h0000_0200; ls_size = 2'b10; ls_we = 1'b1; ls_wdata = w; ls_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("sw_lat", lat, 32'd5);
        check_val("sw_who", done_who, 32'd2);
        for (int k = 1; k <= 4; k++) begin
            check_val("sw_wr", {31'h0, log_wr[k]}, 32'h1);
            check_val("sw_addr", log_a[k], 32'h200 + k - 1);
            check_val("sw_byte", {24'h0, log_d[k]}, {24'h0, w[8*(k-1) +: 8]});
        end
        check_val("sw_wr_end", {31'h0, log_wr[5]}, 32'h0);

        // Second collision after an LSB grant
`ifdef MEM_ARB_FAIR_EN
        exp_first = 1;
`else
        exp_first = 2;
`endif
        ls_addr = 32'h0000_0010; ls_size = 2'b01; ls_we = 1'b0; ls_req = 1'b1;
        if_addr = 32'h0000_0100; if_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("coll2_first", done_who, exp_first);
        check_val("coll2_first_lat", lat, (exp_first == 1) ? 32'd6 : 32'd4);
        run_txn(20, 0, 99, 99, lat);
        check_val("coll2_second", done_who, 3 - exp_first);
        check_val("coll2_second_data", done_data, (exp_first == 1) ? 32'h0000_9234 : 32'h0000_0513);

        // IO byte store stalled 3 cycles by a full UART buffer
        ls_addr = 32'h0003_0000; ls_size = 2'b00; ls_we = 1'b1; ls_wdata = 32'h1234_56A5; ls_req = 1'b1;
        run_txn(20, 3, 99, 99, lat);
        check_val("io_lat", lat, 32'd5);
        for (int k = 1; k <= 3; k++) check_val("io_stall_wr", {31'h0, log_wr[k]}, 32'h0);
        check_val("io_beat_wr", {31'h0, log_wr[4]}, 32'h1);
        check_val("io_beat_addr", log_a[4], 32'h0003_0000);
        check_val("io_beat_byte", {24'h0, log_d[4]}, 32'h0000_00A5);

        // Non-IO store ignores a full UART buffer
        ls_addr = 32'h0002_0300; ls_size = 2'b00; ls_we = 1'b1; ls_wdata = 32'h0000_0077; ls_req = 1'b1;
        run_txn(20, 3, 99, 99, lat);
        check_val("nonio_lat", lat, 32'd2);
        check_val("nonio_byte", {24'h0, log_d[1]}, 32'h0000_0077);

        // Flush two cycles into a fetch, LSB load raised meanwhile
        if_addr = 32'h0000_0100; if_req = 1'b1;
        tick();
        tick();
        snap = if_done_cnt;
        flush_in = 1'b1;
        ls_addr = 32'h0000_0011; ls_size = 2'b00; ls_we = 1'b0; ls_req = 1'b1;
        tick();
        flush_in = 1'b0; if_req = 1'b0;
        run_txn(20, 0, 99, 99, lat);
        check_val("flush_ls_who", done_who, 32'd2);
        check_val("flush_ls_lat", lat, 32'd3);
        check_val("flush_ls_addr", log_a[1], 32'h0000_0011);
        check_val("flush_ls_data", done_data, 32'h0000_0092);
        tick(); tick(); tick(); tick();
        check_val("flush_no_if_done", if_done_cnt, snap);

        // rdy_in low for two cycles after beat 1 issued
        if_addr = 32'h0000_0104; if_req = 1'b1;
        run_txn(20, 0, 3, 4, lat);
        check_val("rdy_lat", lat, 32'd8);
        check_val("rdy_data", done_data, 32'h5D5C_5F5E);
        check_val("rdy_beat1_addr", log_a[2], 32'h0000_0105);
        check_val("rdy_beat2_addr", log_a[5], 32'h0000_0106);
        check_val("rdy_beat3_addr", log_a[6], 32'h0000_0107);

        // Address wrap across 2^32
        if_addr = 32'hFFFF_FFFE; if_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("wrap_lat", lat, 32'd6);
        check_val("wrap_addr2", log_a[2], 32'hFFFF_FFFF);
        check_val("wrap_addr3", log_a[3], 32'h0000_0000);
        check_val("wrap_data", done_data, 32'h5B5A_A5A4);

        // ls_size 11 reads four bytes
        ls_addr = 32'h0000_0100; ls_size = 2'b11; ls_we = 1'b0; ls_req = 1'b1;
        run_txn(20, 0, 99, 99, lat);
        check_val("size3_lat", lat, 32'd6);
        check_val("size3_data", done_data, 32'h0000_0513);

        // Reset in the middle of a store abandons it
        ls_addr = 32'h0000_0200; ls_size = 2'b10; ls_we = 1'b1; ls_wdata = 32'hCAFE_F00D; ls_req = 1'b1;
        tick();
        tick();
        check_val("midrst_pre_wr", {31'h0, mem_wr}, 32'h1);
        snap = ls_done_cnt;
        rst_in = 1'b1;
        tick();
        check_val("midrst_wr", {31'h0, mem_wr}, 32'h0);
        check_val("midrst_addr", mem_a, 32'h0);
        rst_in = 1'b0; ls_req = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_val("midrst_no_done", ls_done_cnt, snap);
        check_val("midrst_idle_wr", {31'h0, mem_wr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
